ps2_mouse_receiver: RTL
=======================

PS2_MOUSE_RECEIVER -- requirements
Module: ps2_mouse_receiver

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 100000, sets the clk cycles without a PS/2 clock falling edge before a partial frame/packet is abandoned.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for i_ps2_clk and i_ps2_data (legal range 2..4).
REQ-003 clk  input  1  system clock.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 i_ps2_clk  input  1  raw PS/2 clock line from the mouse, asynchronous to clk.
REQ-006 i_ps2_data  input  1  raw PS/2 data line from the mouse, asynchronous to clk.
REQ-007 o_mouse_dx  output  8  X movement byte of the last accepted packet (two's-complement low byte).
REQ-008 o_mouse_dy  output  8  Y movement byte of the last accepted packet (two's-complement low byte).
REQ-009 o_is_mouse_dx_neg  output  1  X sign bit (packet byte0 bit4).
REQ-010 o_is_mouse_dy_neg  output  1  Y sign bit (packet byte0 bit5).
REQ-011 o_buttons  output  3  {middle, right, left} from packet byte0 bits [2:0].
REQ-012 o_valid  output  1  one-cycle pulse when all outputs above are updated.
REQ-013 o_frame_err  output  1  one-cycle pulse on any rejected frame, sync loss, or timeout.

Function
REQ-014 Both PS/2 inputs SHALL pass through SYNC_STAGES flip-flops; a falling edge is synced clk going 1->0 between consecutive clk cycles.
REQ-015 Data SHALL be sampled only on a detected falling edge; frame = start(0), 8 data LSB-first, odd parity, stop(1).
REQ-016 Frame FSM states SHALL be IDLE, DATA, PARITY, STOP; IDLE->DATA on edge with data=0, IDLE stays on edge with data=1; DATA->PARITY after the 8th data bit (3-bit counter 0..7); PARITY->STOP on next edge; STOP->IDLE on next edge.
REQ-017 A byte SHALL be accepted at STOP only when stop=1 and (parity check passes per REQ-027); otherwise o_frame_err pulses and the byte counter returns to 0.
REQ-018 A byte counter (0..2) SHALL assemble packets; byte0 accepted only if its bit3=1, else discarded with o_frame_err and counter stays 0 (resync).
REQ-019 On acceptance of byte2, all data outputs SHALL update on the next clk edge together with o_valid=1 for exactly one cycle.
REQ-020 Between packets all data outputs SHALL hold their last values; partial packets SHALL never alter them.
REQ-021 Byte0 overflow bits [7:6] SHALL be ignored; dx/dy pass raw.
REQ-022 An idle counter SHALL reset on every falling edge and saturate at TIMEOUT_CYCLES; reaching it while FSM is not IDLE or byte counter is not 0 SHALL force IDLE, byte counter 0, and pulse o_frame_err once.
REQ-023 Timeout while fully idle (IDLE, counter 0) SHALL produce no error pulse.
REQ-024 o_valid and o_frame_err SHALL never be asserted in the same cycle.

Reset
REQ-025 On arst_n low: FSM IDLE, counters 0, synchronizer flops 1, o_mouse_dx/dy 0, sign bits 0, o_buttons 0, o_valid 0, o_frame_err 0.
REQ-026 Reset asserted mid-frame or mid-packet SHALL discard all partial data; first packet after release is decoded normally.

Configuration
REQ-027 Macro PS2_MOUSE_PARITY_CHECK_EN: defined -> odd-parity mismatch rejects the byte (REQ-017); undefined -> parity bit sampled but ignored, no parity logic synthesized.

Structure
REQ-028 Package ps2_mouse_pkg SHALL hold the frame-state enum, packet byte-0 bit-position constants, and a packet struct {buttons, dx_neg, dy_neg, dx, dy}.
REQ-029 Sub-module ps2_frame_rx SHALL implement synchronizer, edge detect, frame FSM, and timeout, emitting byte + byte_valid + byte_err to the packet assembler in the top.

Verification
REQ-030 Packet 0x08,0x05,0xFB sent at 12.5 kHz -> one o_valid; dx=0x05, dy=0xFB, dx_neg=0, dy_neg=0, buttons=000.
REQ-031 Packet 0x39,0xF0,0x10 -> dx=0xF0, dx_neg=1, dy_neg=1, buttons=001.
REQ-032 Byte with flipped parity (parity check enabled) -> o_frame_err pulse, no o_valid; next clean packet decodes correctly.
REQ-033 Stray byte 0x00 then packet 0x09,0x01,0x02 -> one o_frame_err, then o_valid with buttons=001, dx=0x01, dy=0x02.
REQ-034 Two bytes then silence > TIMEOUT_CYCLES -> one o_frame_err, outputs unchanged; next full packet accepted.
REQ-035 arst_n pulsed low after 5 bits of byte1 -> all outputs 0; following packet 0x08,0x7F,0x80 -> dx=0x7F, dy=0x80.

Source files
------------

// File: rtl/ps2_mouse_pkg.sv
// Shared types for the PS/2 mouse receiver: frame FSM states, byte-0 bit
// positions and the decoded packet record.
package ps2_mouse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_e;

    localparam int unsigned B0_LEFT_BIT   = 0;
    localparam int unsigned B0_MIDDLE_BIT = 2;
    localparam int unsigned B0_SYNC_BIT   = 3;
    localparam int unsigned B0_X_SIGN_BIT = 4;
    localparam int unsigned B0_Y_SIGN_BIT = 5;

    typedef struct packed {
        logic [2:0] buttons;
        logic       dx_neg;
        logic       dy_neg;
        logic [7:0] dx;
        logic [7:0] dy;
    } mouse_pkt_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
        return ^{parity, data};
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input synchronizers, falling-edge detect, 11-bit frame FSM
// and inactivity timeout. Parity rejection only when PS2_MOUSE_PARITY_CHECK_EN is defined.
module ps2_frame_rx
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_pkt_busy,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_byte_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    frame_state_e           state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [7:0]             shift_q, shift_d;
    logic [7:0]             byte_q, byte_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   byte_err_q, byte_err_d;
    logic [CNT_W-1:0]       idle_cnt_q, idle_cnt_d;
    logic                   fall_s, data_s, timeout_s, par_ok_s;

    assign fall_s = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    assign data_s = data_sync_q[SYNC_STAGES-1];

`ifdef PS2_MOUSE_PARITY_CHECK_EN
    logic par_q, par_d;

    // Capture the parity bit on the edge that closes the PARITY state
    always_comb begin
        if (fall_s && (state_q == ST_PARITY)) begin
            par_d = data_s;
        end else begin
            par_d = par_q;
        end
    end

    // Parity bit register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            par_q <= 1'b1;
        end else begin
            par_q <= par_d;
        end
    end

    assign par_ok_s = odd_parity_ok(shift_q, par_q);
`else
    assign par_ok_s = 1'b1;
`endif

    // Synchronizer shift, edge history and frame FSM next-state
    always_comb begin
        clk_sync_d   = {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
        data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], i_ps2_data};
        clk_prev_d   = clk_sync_q[SYNC_STAGES-1];
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        byte_err_d   = 1'b0;
        if (fall_s) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != TIMEOUT_VAL) begin
            idle_cnt_d = idle_cnt_q + CNT_W'(1);
        end else begin
            idle_cnt_d = idle_cnt_q;
        end
        // Fires only on the cycle the counter arrives at the limit, so at most once per silence
        timeout_s = !fall_s && (idle_cnt_q == TIMEOUT_M1);

        if (timeout_s) begin
            byte_err_d = (state_q != ST_IDLE) || i_pkt_busy;
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
        end else if (fall_s) begin
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    shift_d = {data_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d   = ST_PARITY;
                        bit_cnt_d = 3'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                ST_PARITY: begin
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (data_s && par_ok_s) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        byte_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State registers; synchronizers idle high like the bus
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            clk_prev_q   <= 1'b1;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            byte_q       <= 8'd0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
            idle_cnt_q   <= '0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            byte_err_q   <= byte_err_d;
            idle_cnt_q   <= idle_cnt_d;
        end
    end

    assign o_byte       = byte_q;
    assign o_byte_valid = byte_valid_q;
    assign o_byte_err   = byte_err_q;

endmodule

// File: rtl/ps2_mouse_receiver.sv
// PS/2 mouse receiver top: assembles 3-byte movement packets from ps2_frame_rx.
// Optional parity rejection via PS2_MOUSE_PARITY_CHECK_EN.
module ps2_mouse_receiver
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_mouse_dx,
    output logic [7:0] o_mouse_dy,
    output logic       o_is_mouse_dx_neg,
    output logic       o_is_mouse_dy_neg,
    output logic [2:0] o_buttons,
    output logic       o_valid,
    output logic       o_frame_err
);

    logic [7:0] rx_byte_s;
    logic       rx_valid_s, rx_err_s, pkt_busy_s;
    logic [1:0] byte_cnt_q, byte_cnt_d;
    mouse_pkt_t stage_q, stage_d;
    mouse_pkt_t out_q, out_d;
    logic       valid_q, valid_d;
    logic       err_q, err_d;

    assign pkt_busy_s = (byte_cnt_q != 2'd0);

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
    ) u_frame_rx (
        .clk         (clk),
        .arst_n      (arst_n),
        .i_ps2_clk   (i_ps2_clk),
        .i_ps2_data  (i_ps2_data),
        .i_pkt_busy  (pkt_busy_s),
        .o_byte      (rx_byte_s),
        .o_byte_valid(rx_valid_s),
        .o_byte_err  (rx_err_s)
    );

    // Packet assembly; outputs only move when the third byte lands
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        stage_d    = stage_q;
        out_d      = out_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        if (rx_err_s) begin
            err_d      = 1'b1;
            byte_cnt_d = 2'd0;
        end else if (rx_valid_s) begin
            case (byte_cnt_q)
                2'd0: begin
                    // Bit 3 is always set in a real byte 0; anything else means we are out of step
                    if (rx_byte_s[B0_SYNC_BIT]) begin
                        stage_d.buttons = rx_byte_s[B0_MIDDLE_BIT:B0_LEFT_BIT];
                        stage_d.dx_neg  = rx_byte_s[B0_X_SIGN_BIT];
                        stage_d.dy_neg  = rx_byte_s[B0_Y_SIGN_BIT];
                        byte_cnt_d      = 2'd1;
                    end else begin
                        err_d      = 1'b1;
                        byte_cnt_d = 2'd0;
                    end
                end
                2'd1: begin
                    stage_d.dx = rx_byte_s;
                    byte_cnt_d = 2'd2;
                end
                2'd2: begin
                    out_d      = stage_q;
                    out_d.dy   = rx_byte_s;
                    valid_d    = 1'b1;
                    byte_cnt_d = 2'd0;
                end
                default: begin
                    byte_cnt_d = 2'd0;
                end
            endcase
        end else begin
            byte_cnt_d = byte_cnt_q;
        end
    end

    // Packet and output registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            byte_cnt_q <= 2'd0;
            stage_q    <= '0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            stage_q    <= stage_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign o_mouse_dx        = out_q.dx;
    assign o_mouse_dy        = out_q.dy;
    assign o_is_mouse_dx_neg = out_q.dx_neg;
    assign o_is_mouse_dy_neg = out_q.dy_neg;
    assign o_buttons         = out_q.buttons;
    assign o_valid           = valid_q;
    assign o_frame_err       = err_q;

endmodule
